mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_pkg.sv | 35 +++
 rtl/mem_access_unit_if.sv | 18 +
 rtl/mem_load_ext.sv | 27 ++
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: Funct3 access-size codes,
// FSM state type and the store-side byte-enable / lane-replication helpers.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Funct3[1:0] carries the size: 00 byte, 01 half, anything else word.
    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b00:   byte_enables = 4'b0001 << a;
            2'b01:   byte_enables = a[1] ? 4'b1100 : 4'b0011;
            default: byte_enables = 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane so the SRAM picks it up via mem_be.
    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   lane_data = {4{d[7:0]}};
            2'b01:   lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// SRAM-side bus of the memory access unit.
// Handshake: mem_req stays high for every cycle of an access; the SRAM
// completes it by raising mem_ready for one cycle, with mem_rdata valid in
// that same cycle. mem_we/mem_addr/mem_be/mem_wdata are stable while mem_req=1.
interface mem_access_unit_if #(parameter int ADDR_W = 10);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_ready, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_load_ext.sv
// Load lane selection and sign/zero extension of a raw SRAM word.
// Reserved Funct3 codes pass the full word through, like lw.
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, then extend according to the access type.
    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        ext      = rdata;
        case (funct3)
            F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ext = {24'b0, byte_sel};
            F3_H:    ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ext = {16'b0, half_sel};
            default: ext = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: turns a load/store request into one SRAM
// access, stalls the pipeline while waiting, and gives up after TIMEOUT
// BUSY cycles. Optional macro MEM_MISALIGN_CHECK_EN rejects misaligned
// half/word accesses without touching the SRAM.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Stall,
    output logic        Done,
    output logic        Err,
    output state_t      state_dbg,
    mem_access_unit_if.master mem
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              is_load_q;
    logic [2:0]        f3_q;
    logic [1:0]        alo_q;
    logic              err_q;
    logic [31:0]       ext_data;
    logic              req, misalign, start, ready_hit, timeout_hit, fail_fast;
    logic              addr_unused;

    assign addr_unused = ^Addr[31:ADDR_W+2];
    assign req         = MemRead | MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                      (Funct3[1] && (Addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    mem_load_ext u_load_ext (
        .rdata   (mem.mem_rdata),
        .addr_lo (alo_q),
        .funct3  (f3_q),
        .ext     (ext_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state decode and transition strobes.
    always_comb begin
        state_nx    = state;
        start       = 1'b0;
        ready_hit   = 1'b0;
        timeout_hit = 1'b0;
        fail_fast   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (misalign) begin
                        fail_fast = 1'b1;
                        state_nx  = ST_DONE;
                    end else begin
                        start    = 1'b1;
                        state_nx = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (mem.mem_ready) begin
                    ready_hit = 1'b1;
                    state_nx  = ST_DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nx    = ST_DONE;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign Stall     = ((state == ST_IDLE) && req && !misalign) || (state == ST_BUSY);
    assign Done      = (state == ST_DONE);
    assign Err       = err_q;
    assign state_dbg = state;

    // SRAM request registers, wait counter, load result and error flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= 4'b0;
            mem.mem_wdata <= 32'b0;
            RdData        <= 32'b0;
            cnt           <= '0;
            is_load_q     <= 1'b0;
            f3_q          <= 3'b0;
            alo_q         <= 2'b0;
            err_q         <= 1'b0;
        end else begin
            err_q <= timeout_hit | fail_fast;
            if (start) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= MemWrite;
                mem.mem_addr  <= Addr[ADDR_W+1:2];
                mem.mem_be    <= byte_enables(Funct3, Addr[1:0]);
                mem.mem_wdata <= lane_data(Funct3, WrData);
                is_load_q     <= ~MemWrite;
                f3_q          <= Funct3;
                alo_q         <= Addr[1:0];
                cnt           <= '0;
            end else if (state == ST_BUSY) begin
                cnt <= cnt + 1'b1;
                if (ready_hit || timeout_hit) mem.mem_req <= 1'b0;
                if (ready_hit && is_load_q)   RdData <= ext_data;
                if (timeout_hit)              RdData <= 32'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases then randomized loads/stores
// against a behavioural model of the access rules and an SRAM responder.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [2:0]  Funct3 = 3'b0;
    logic [31:0] Addr = 32'b0, WrData = 32'b0;
    logic [31:0] RdData;
    logic        Stall, Done, Err;
    state_t      state_dbg;

    mem_access_unit_if #(.ADDR_W(ADDR_W)) mem_bus ();

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .RdData(RdData),
        .Stall(Stall), .Done(Done), .Err(Err), .state_dbg(state_dbg),
        .mem(mem_bus.master)
    );

    // Clock and reset
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_model = 32'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference rules written from the access-size definitions.
    function automatic int size_of(input logic [2:0] f3);
        return (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] d);
        logic [31:0] v;
        logic        uns;
        uns = (f3 == 3'b100) || (f3 == 3'b101);
        if (size_of(f3) == 1) begin
            v = (d >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 128) v = v | 32'hFFFF_FF00;
        end else if (size_of(f3) == 2) begin
            v = ((a & 2) != 0) ? (d >> 16) : (d & 32'hFFFF);
            if (!uns && v >= 32768) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        if (size_of(f3) == 1) return 32'd1 << (a % 4);
        if (size_of(f3) == 2) return ((a & 2) != 0) ? 32'd12 : 32'd3;
        return 32'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (size_of(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
        if (size_of(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
        return (size_of(f3) == 2 && (a % 2) != 0) || (size_of(f3) == 4 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0;
        mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = 32'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rd_model = 32'b0;
    endtask

    // Driver: one request, called at posedge+1 of an IDLE cycle. The SRAM
    // answers on BUSY cycle number `delay` (0-based); delay >= TIMEOUT means never.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int delay, input logic [31:0] rdata);
        bit  is_store, misal, timed_out;
        int  k;
        is_store  = wr;
        misal     = model_misaligned(f3, a);
        timed_out = (delay >= TIMEOUT) && !misal;
        if (misal)               exp_q.push_back(rd_model);
        else if (timed_out)      exp_q.push_back(32'b0);
        else if (is_store)       exp_q.push_back(rd_model);
        else                     exp_q.push_back(model_load(f3, a, rdata));

        MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
        mem_bus.mem_ready = 1'($urandom_range(0, 1));
        mem_bus.mem_rdata = $urandom;
        @(negedge clk);
        check("stall_idle", 32'(Stall), misal ? 32'd0 : 32'd1);
        check("done_idle", 32'(Done), 32'd0);
        if (!misal) begin
            for (k = 0; k < TIMEOUT; k++) begin
                @(posedge clk);
                #1;
                mem_bus.mem_ready = (k == delay);
                mem_bus.mem_rdata = (k == delay) ? rdata : $urandom;
                @(negedge clk);
                check("stall_busy", 32'(Stall), 32'd1);
                check("req_busy", 32'(mem_bus.mem_req), 32'd1);
                if (k == 0) begin
                    check("mem_we", 32'(mem_bus.mem_we), 32'(is_store));
                    check("mem_addr", 32'(mem_bus.mem_addr), (a >> 2) & ((32'd1 << ADDR_W) - 1));
                    check("mem_be", 32'(mem_bus.mem_be), model_be(f3, a));
                    if (is_store) check("mem_wdata", mem_bus.mem_wdata, model_wdata(f3, wd));
                end
                if (k == delay) break;
            end
        end else begin
            check("req_misal", 32'(mem_bus.mem_req), 32'd0);
        end
        @(posedge clk);
        #1;
        MemRead = 1'b0; MemWrite = 1'b0;
        mem_bus.mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("done", 32'(Done), 32'd1);
        check("err", 32'(Err), (timed_out || misal) ? 32'd1 : 32'd0);
        check("stall_done", 32'(Stall), 32'd0);
        check("req_done", 32'(mem_bus.mem_req), 32'd0);
        rd_model = exp_q.pop_front();
        check("rddata", RdData, rd_model);
        @(posedge clk);
        #1 mem_bus.mem_ready = 1'b0;
        @(negedge clk);
        check("done_pulse", 32'(Done), 32'd0);
        check("err_pulse", 32'(Err), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{F3_B, F3_H, F3_W, F3_BU, F3_HU, 3'b011, 3'b110, 3'b111};

        do_reset();
        @(negedge clk);
        check("rst_rddata", RdData, 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        check("rst_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_we", 32'(mem_bus.mem_we), 32'd0);
        check("rst_be", 32'(mem_bus.mem_be), 32'd0);
        check("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("rst_wdata", mem_bus.mem_wdata, 32'd0);
        check("rst_stall", 32'(Stall), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        @(posedge clk);
        #1;

        // Directed cases
        run_txn(1, 0, F3_W,  32'h10, 32'h0, 1, 32'hDEAD_BEEF);
        check("lw_result", RdData, 32'hDEAD_BEEF);
        run_txn(1, 0, F3_B,  32'h13, 32'h0, 0, 32'h80FF_FF00);
        check("lb_result", RdData, 32'hFFFF_FF80);
        run_txn(1, 0, F3_BU, 32'h13, 32'h0, 2, 32'h80FF_FF00);
        check("lbu_result", RdData, 32'h0000_0080);
        run_txn(1, 1, F3_H,  32'h22, 32'h1234_ABCD, 1, 32'h5555_5555);
        check("sh_keep", RdData, 32'h0000_0080);
        run_txn(1, 0, F3_W,  32'h40, 32'h0, TIMEOUT, 32'h0);
        check("timeout_result", RdData, 32'd0);
        run_txn(1, 0, F3_W,  32'h44, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D);

        // Reset in the second BUSY cycle: back to IDLE with no completion pulse.
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = F3_W; Addr = 32'h80;
        @(posedge clk);
        #1 mem_bus.mem_ready = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1; MemRead = 1'b0;
        @(negedge clk);
        check("rstbusy_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rstbusy_req", 32'(mem_bus.mem_req), 32'd0);
        check("rstbusy_done", 32'(Done), 32'd0);
        check("rstbusy_rddata", RdData, 32'd0);
        rd_model = 32'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rstbusy_done2", 32'(Done), 32'd0);
        @(posedge clk);
        #1;

`ifdef MEM_MISALIGN_CHECK_EN
        run_txn(1, 0, F3_W, 32'h3, 32'h0, 0, 32'h1111_1111);
`endif

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            int          op, dly;
            logic [2:0]  f3;
            op  = $urandom_range(0, 3);
            f3  = f3_tab[$urandom_range(0, 7)];
            dly = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT)
                                              : $urandom_range(0, 5);
            run_txn(op != 1, op == 1 || op == 2, f3, $urandom, $urandom, dly, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
